// File: rtl/atm_key_entry.sv
// atm_key_entry: collects ASCII key strobes from the key decoder into BCD digits,
// a menu choice or a currency choice depending on the entry mode armed by start.
// Supports backspace, quit, idle timeout and a start/done handshake toward the
// main ATM control FSM.
module atm_key_entry #(
   parameter int ACC_DIGITS     = 4,
   parameter int PIN_DIGITS     = 4,
   parameter int AMT_DIGITS     = 8,
   parameter int TIMEOUT_CYCLES = 300_000_000
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start,
   input  logic [3:0]                        mode_in,
   input  logic                              key_valid,
   input  logic [7:0]                        key_code,
   output logic                              key_ready,
   output logic [4*AMT_DIGITS-1:0]           digits_out,
   output logic [$clog2(AMT_DIGITS+1)-1:0]   digit_count,
   output logic [1:0]                        menu_sel,
   output logic [2:0]                        currency_sel,
   output logic [3:0]                        status_code,
   output logic                              done,
   output logic                              busy
);

   localparam int DW = 4 * AMT_DIGITS;
   localparam int CW = $clog2(AMT_DIGITS + 1);
   localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   localparam logic [3:0] M_SINGLE = 4'd1;
   localparam logic [3:0] M_ACC    = 4'd2;
   localparam logic [3:0] M_PIN    = 4'd3;
   localparam logic [3:0] M_MENU   = 4'd4;
   localparam logic [3:0] M_CUR    = 4'd5;
   localparam logic [3:0] M_AMT    = 4'd6;

   localparam logic [3:0] S_EXIT     = 4'd7;
   localparam logic [3:0] S_COMPLETE = 4'd8;
   localparam logic [3:0] S_TIMEOUT  = 4'd9;
   localparam logic [3:0] S_BAD_MODE = 4'd10;

   localparam logic [7:0] K_QUIT  = 8'h71;
   localparam logic [7:0] K_ENTER = 8'h0D;
   localparam logic [7:0] K_BS    = 8'h08;

   typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_FINISH} state_t;

   state_t          state;
   logic [3:0]      mode_reg;
   logic [TW-1:0]   timer;
   logic            menu_set;
   logic            cur_set;

   logic            mode_ok;
   logic            is_digit;
   logic            is_cur_key;
   logic [CW-1:0]   digit_limit;
   logic            enter_ok;
   logic [DW-1:0]   digits_shl;

   assign mode_ok    = (mode_in >= M_SINGLE) && (mode_in <= M_AMT);
   assign is_digit   = (key_code >= 8'h30) && (key_code <= 8'h39);
   assign is_cur_key = (key_code >= 8'h31) && (key_code <= 8'h35);
   // Shift the new digit in at the bottom; the top nibble falls off (never nonzero
   // because the count limit stops shifting before the register is full).
   assign digits_shl = DW'({digits_out, key_code[3:0]});

   // Per-mode digit limit and whether Enter may complete the entry now.
   always_comb begin
      digit_limit = CW'(AMT_DIGITS);
      enter_ok    = 1'b0;
      case (mode_reg)
         M_SINGLE: enter_ok = 1'b1;
         M_ACC: begin
            digit_limit = CW'(ACC_DIGITS);
            enter_ok    = (digit_count == CW'(ACC_DIGITS));
         end
         M_PIN: begin
            digit_limit = CW'(PIN_DIGITS);
            enter_ok    = (digit_count == CW'(PIN_DIGITS));
         end
         M_AMT:   enter_ok = (digit_count != '0);
         M_MENU:  enter_ok = menu_set;
         M_CUR:   enter_ok = cur_set;
         default: enter_ok = 1'b0;
      endcase
   end

   // Entry FSM with all outputs registered; start outside FINISH always re-arms.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         mode_reg     <= '0;
         timer        <= '0;
         menu_set     <= 1'b0;
         cur_set      <= 1'b0;
         key_ready    <= 1'b0;
         digits_out   <= '0;
         digit_count  <= '0;
         menu_sel     <= '0;
         currency_sel <= '0;
         status_code  <= '0;
         done         <= 1'b0;
         busy         <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start && state != ST_FINISH) begin
            // Any key presented in the same cycle is dropped by taking this branch.
            digits_out   <= '0;
            digit_count  <= '0;
            menu_sel     <= '0;
            currency_sel <= '0;
            menu_set     <= 1'b0;
            cur_set      <= 1'b0;
            timer        <= '0;
            mode_reg     <= mode_in;
            busy         <= 1'b1;
            if (mode_ok) begin
               state       <= ST_COLLECT;
               key_ready   <= 1'b1;
               status_code <= '0;
            end else begin
               state       <= ST_FINISH;
               key_ready   <= 1'b0;
               status_code <= S_BAD_MODE;
            end
         end else begin
            case (state)
               ST_COLLECT: begin
                  if (key_valid) begin
                     timer <= '0;
                     if (key_code == K_QUIT) begin
                        state       <= ST_FINISH;
                        key_ready   <= 1'b0;
                        status_code <= S_EXIT;
                     end else if (key_code == K_ENTER) begin
                        if (enter_ok) begin
                           state       <= ST_FINISH;
                           key_ready   <= 1'b0;
                           status_code <= S_COMPLETE;
                        end
                     end else begin
                        case (mode_reg)
                           M_ACC, M_PIN, M_AMT: begin
                              if (is_digit && digit_count < digit_limit) begin
                                 digits_out  <= digits_shl;
                                 digit_count <= digit_count + CW'(1);
                              end else if (key_code == K_BS && digit_count != '0) begin
                                 digits_out  <= digits_out >> 4;
                                 digit_count <= digit_count - CW'(1);
                              end
                           end
                           M_MENU: begin
                              menu_set <= (key_code == 8'h62) || (key_code == 8'h63) ||
                                          (key_code == 8'h77) || (key_code == 8'h74) || menu_set;
                              case (key_code)
                                 8'h62:   menu_sel <= 2'd0;
                                 8'h63:   menu_sel <= 2'd1;
                                 8'h77:   menu_sel <= 2'd2;
                                 8'h74:   menu_sel <= 2'd3;
                                 default: menu_sel <= menu_sel;
                              endcase
                           end
                           M_CUR: begin
                              if (is_cur_key) begin
                                 currency_sel <= key_code[2:0] - 3'd1;
                                 cur_set      <= 1'b1;
                              end
                           end
                           default: ;
                        endcase
                     end
                  end else if (TIMEOUT_CYCLES != 0) begin
                     if (timer == T_LAST) begin
                        state       <= ST_FINISH;
                        key_ready   <= 1'b0;
                        status_code <= S_TIMEOUT;
                     end else begin
                        timer <= timer + TW'(1);
                     end
                  end
               end
               ST_FINISH: begin
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  key_ready <= 1'b0;
                  state     <= ST_IDLE;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
